// File: rtl/xadc_scan_bcd.sv
// XADC auxiliary-channel scanner: EOC-paced DRP reads, code -> mV -> 4-digit BCD, per-channel result file.
// Optional macro XADC_OVERSAMPLE_EN averages four reads per channel before conversion.
module xadc_scan_bcd #(
    parameter int                  NUM_CH      = 4,
    parameter logic [NUM_CH*7-1:0] CH_ADDRS    = {7'h11, 7'h19, 7'h18, 7'h10},
    parameter int                  TIMEOUT_CYC = 255,
    localparam int                 CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            CLK100MHZ,
    input  logic            cpu_resetn,
    input  logic            eoc_in,
    output logic [6:0]      drp_daddr,
    output logic            drp_den,
    output logic            drp_dwe,
    output logic [15:0]     drp_di,
    input  logic [15:0]     drp_do,
    input  logic            drp_drdy,
    input  logic [CH_W-1:0] rd_ch,
    output logic [15:0]     rd_bcd,
    output logic            rd_valid,
    output logic            res_valid,
    output logic [CH_W-1:0] res_ch,
    output logic [15:0]     res_bcd,
    output logic            timeout_err,
    input  logic            err_clr
);
    localparam int              TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int              SLOTS    = 1 << CH_W;
    localparam logic [CH_W:0]   NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SCALE, S_BCD, S_STORE} state_t;

    state_t            state_reg, state_next;
    logic [CH_W-1:0]   idx_reg;
    logic              pend_reg;
    logic [TMR_W-1:0]  tmr_reg;
    logic [11:0]       code_reg;
    logic [9:0]        bin_reg;
    logic [15:0]       bcd_reg;
    logic [3:0]        bit_cnt_reg;
    logic [15:0]       regfile [SLOTS];
    logic [SLOTS-1:0]  valid_reg;
    logic [15:0]       rd_bcd_reg, res_bcd_reg;
    logic              rd_valid_reg, res_valid_reg, timeout_err_reg;
    logic [CH_W-1:0]   res_ch_reg;

    logic              enter_req, drdy_hit, tmo_hit, store_hit, last_sub;
    logic [11:0]       code_in;
    logic [9:0]        mv;
    logic [15:0]       bcd_adj;
    logic [6:0]        addr_tab [SLOTS];
    logic              rd_in_range;

    genvar gi;
    for (gi = 0; gi < SLOTS; gi++) begin : g_addr
        if (gi < NUM_CH) begin : g_live
            assign addr_tab[gi] = CH_ADDRS[gi*7 +: 7];
        end else begin : g_pad
            assign addr_tab[gi] = 7'h00;
        end
    end

    // Double-dabble correction: any digit >= 5 gets +3 before the shift.
    for (gi = 0; gi < 4; gi++) begin : g_dig
        assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ? bcd_reg[gi*4 +: 4] + 4'd3
                                                                 : bcd_reg[gi*4 +: 4];
    end

    // Full scale saturates at 1000 mV; below that the truncated ratio code*1000/4096.
    assign mv = (code_reg >= 12'd4093) ? 10'd1000
                                       : 10'(({10'd0, code_reg} * 22'd1000) >> 12);

    assign drp_daddr   = addr_tab[idx_reg];
    assign drp_den     = (state_reg == S_REQ);
    assign drp_dwe     = 1'b0;
    assign drp_di      = 16'h0000;
    assign rd_bcd      = rd_bcd_reg;
    assign rd_valid    = rd_valid_reg;
    assign res_valid   = res_valid_reg;
    assign res_ch      = res_ch_reg;
    assign res_bcd     = res_bcd_reg;
    assign timeout_err = timeout_err_reg;
    assign rd_in_range = ({1'b0, rd_ch} < NUM_CH_L);

`ifdef XADC_OVERSAMPLE_EN
    logic [1:0]  sub_reg;
    logic [13:0] acc_reg;
    logic [13:0] acc_sum;
    logic        unused_bits;

    assign acc_sum     = acc_reg + {2'b00, drp_do[15:4]};
    assign last_sub    = (sub_reg == 2'd3);
    assign code_in     = acc_sum[13:2];
    assign unused_bits = ^{drp_do[3:0], acc_sum[1:0], bcd_adj[15]};

    always_ff @(posedge CLK100MHZ or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            sub_reg <= '0;
            acc_reg <= '0;
        end else if (tmo_hit) begin
            sub_reg <= '0;
            acc_reg <= '0;
        end else if (drdy_hit) begin
            sub_reg <= sub_reg + 2'd1;
            acc_reg <= last_sub ? 14'd0 : acc_sum;
        end
    end
`else
    logic unused_bits;

    assign last_sub    = 1'b1;
    assign code_in     = drp_do[15:4];
    assign unused_bits = ^{drp_do[3:0], bcd_adj[15]};
`endif

    always_ff @(posedge CLK100MHZ or negedge cpu_resetn) begin
        if (!cpu_resetn) state_reg <= S_IDLE;
        else             state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        enter_req  = 1'b0;
        drdy_hit   = 1'b0;
        tmo_hit    = 1'b0;
        store_hit  = 1'b0;
        case (state_reg)
            S_IDLE: if (pend_reg) begin
                state_next = S_REQ;
                enter_req  = 1'b1;
            end
            S_REQ:  state_next = S_WAIT;
            S_WAIT: if (drp_drdy) begin
                drdy_hit   = 1'b1;
                state_next = last_sub ? S_SCALE : S_IDLE;
            end else if (tmr_reg == TMR_LAST) begin
                tmo_hit    = 1'b1;
                state_next = S_IDLE;
            end
            S_SCALE: state_next = S_BCD;
            S_BCD:   if (bit_cnt_reg == 4'd9) state_next = S_STORE;
            S_STORE: begin
                store_hit  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            idx_reg         <= '0;
            pend_reg        <= 1'b0;
            tmr_reg         <= '0;
            code_reg        <= '0;
            bin_reg         <= '0;
            bcd_reg         <= '0;
            bit_cnt_reg     <= '0;
            res_valid_reg   <= 1'b0;
            res_ch_reg      <= '0;
            res_bcd_reg     <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            // A fresh eoc always wins over the clear on REQ entry, so none is lost.
            pend_reg <= eoc_in | (pend_reg & ~enter_req);

            if (state_reg == S_REQ)       tmr_reg <= '0;
            else if (state_reg == S_WAIT) tmr_reg <= tmr_reg + 1'b1;

            if (drdy_hit && last_sub) code_reg <= code_in;

            if (state_reg == S_SCALE) begin
                bin_reg     <= mv;
                bcd_reg     <= '0;
                bit_cnt_reg <= '0;
            end else if (state_reg == S_BCD) begin
                bcd_reg     <= {bcd_adj[14:0], bin_reg[9]};
                bin_reg     <= {bin_reg[8:0], 1'b0};
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end

            res_valid_reg <= store_hit;
            if (store_hit) begin
                res_bcd_reg <= bcd_reg;
                res_ch_reg  <= idx_reg;
            end

            if (store_hit || tmo_hit)
                idx_reg <= (idx_reg == LAST_CH) ? '0 : idx_reg + 1'b1;

            if (tmo_hit)      timeout_err_reg <= 1'b1;
            else if (err_clr) timeout_err_reg <= 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            for (int i = 0; i < SLOTS; i++) regfile[i] <= '0;
            valid_reg    <= '0;
            rd_bcd_reg   <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            if (store_hit) begin
                regfile[idx_reg]   <= bcd_reg;
                valid_reg[idx_reg] <= 1'b1;
            end
            rd_bcd_reg   <= rd_in_range ? regfile[rd_ch] : 16'h0000;
            rd_valid_reg <= rd_in_range & valid_reg[rd_ch];
        end
    end
endmodule
